// File: rtl/rtm_pkg.sv
// rtm_pkg: shared constants and types for resp_timeout_monitor.
//   - Knight's Tour protocol response bytes and the gyro calibration command
//   - default cycle budgets for the usual things a channel is armed to watch
//   - per-channel state encoding
package rtm_pkg;

  localparam logic [7:0]  POS_ACK  = 8'hA5;
  localparam logic [7:0]  ACK      = 8'h5A;
  localparam logic [15:0] CAL_GYRO = 16'h2000;

  localparam int CMD_SENT_TMO = 60000;
  localparam int RESP_TMO     = 60000;
  localparam int MOVE_TMO     = 12000000;
  localparam int CAL_TMO      = 30000000;
  localparam int SOL_TMO      = 8000000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} rtm_state_t;

endpackage

// File: rtl/rtm_chan.sv
// rtm_chan: one monitor channel.
//   Arm latches a budget, a compare enable and an expected byte, then the
//   channel waits for a rising edge on evt. It resolves as pass, mismatch or
//   timeout, and flags a stray rise when one arrives while idle.
// Ports:
//   clk, rst           clock, async active-high reset
//   arm                start/restart strobe
//   limit/chk_en/exp_data  request fields, latched on arm
//   evt, evt_data      completion level signal and its data
//   busy               armed and waiting
//   done, pass         registered one-cycle resolve pulses
//   tmo_hit/mis_hit/stray_hit  combinational error flags; they land in the
//                      parent's sticky bits on the same edge that raises done
module rtm_chan
  import rtm_pkg::*;
#(
  parameter int CNT_W  = 26,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [CNT_W-1:0]  limit,
  input  logic              chk_en,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              evt,
  input  logic [DATA_W-1:0] evt_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              tmo_hit,
  output logic              mis_hit,
  output logic              stray_hit
);

  rtm_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  lim_q;
  logic              chk_q;
  logic [DATA_W-1:0] exp_q;
  logic              evt_q;
  logic              rise, last_cyc, ld, done_nx, pass_nx;

  assign rise     = evt & ~evt_q;
  // budget exhausted after this cycle; limit 0 disables the timeout
  assign last_cyc = (lim_q != '0) && (cnt == lim_q - 1'b1);
  assign busy     = (state == WAIT);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ld        = 1'b0;
    done_nx   = 1'b0;
    pass_nx   = 1'b0;
    tmo_hit   = 1'b0;
    mis_hit   = 1'b0;
    stray_hit = 1'b0;
    case (state)
      IDLE: begin
        // a rise coinciding with arm belongs to neither request
        if (!arm && rise) stray_hit = 1'b1;
      end
      WAIT: begin
        if (rise) begin
          // rise in the last budget cycle still wins over the timeout
          done_nx  = 1'b1;
          state_nx = IDLE;
          if (chk_q && (evt_data != exp_q)) mis_hit = 1'b1;
          else                              pass_nx = 1'b1;
        end else if (arm) begin
          // silent restart handled below
        end else if (last_cyc) begin
          done_nx  = 1'b1;
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // arm always (re)starts; with a same-cycle rise the old request has
    // already resolved above
    if (arm) begin
      state_nx = WAIT;
      cnt_nx   = '0;
      ld       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lim_q <= '0;
      chk_q <= 1'b0;
      exp_q <= '0;
      evt_q <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      evt_q <= evt;
      done  <= done_nx;
      pass  <= pass_nx;
      if (ld) begin
        lim_q <= limit;
        chk_q <= chk_en;
        exp_q <= exp_data;
      end
    end
  end

endmodule

// File: rtl/resp_timeout_monitor.sv
// resp_timeout_monitor: NUM_CH independent response/timeout channels plus a
// sticky error summary.
// Ports:
//   clk, rst       clock, async active-high reset
//   arm, limit, chk_en, exp_data   per-channel request (latched on arm)
//   evt, evt_data  per-channel completion level signal and data
//   clr_err        clears sticky bits, err_cnt and first_err_ch
//   busy, done, pass               per-channel status / resolve pulses
//   tmo_err, mis_err, stray_err    per-channel sticky error bits
//   any_err        OR of all sticky bits
//   first_err_ch   lowest channel flagging in the first error cycle
//   err_cnt        saturating count of error events
module resp_timeout_monitor
  import rtm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 26,
  parameter int DATA_W   = 8,
  parameter int ERRCNT_W = 8,
  localparam int FE_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              arm,
  input  logic [NUM_CH-1:0][CNT_W-1:0]   limit,
  input  logic [NUM_CH-1:0]              chk_en,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  exp_data,
  input  logic [NUM_CH-1:0]              evt,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  evt_data,
  input  logic                           clr_err,
  output logic [NUM_CH-1:0]              busy,
  output logic [NUM_CH-1:0]              done,
  output logic [NUM_CH-1:0]              pass,
  output logic [NUM_CH-1:0]              tmo_err,
  output logic [NUM_CH-1:0]              mis_err,
  output logic [NUM_CH-1:0]              stray_err,
  output logic                           any_err,
  output logic [FE_W-1:0]                first_err_ch,
  output logic [ERRCNT_W-1:0]            err_cnt
);

  localparam int NW = $clog2(NUM_CH + 1);
  localparam int SW = ERRCNT_W + NW;

  logic [NUM_CH-1:0]   tmo_hit, mis_hit, stray_hit, flag;
  logic [NW-1:0]       n_flag;
  logic [FE_W-1:0]     lo_ch, first_nx;
  logic [ERRCNT_W-1:0] cnt_base, cnt_nx;
  logic [SW-1:0]       sum;
  logic                rec_q, rec_base, rec_nx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rtm_chan #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .arm       (arm[g]),
      .limit     (limit[g]),
      .chk_en    (chk_en[g]),
      .exp_data  (exp_data[g]),
      .evt       (evt[g]),
      .evt_data  (evt_data[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .tmo_hit   (tmo_hit[g]),
      .mis_hit   (mis_hit[g]),
      .stray_hit (stray_hit[g])
    );
  end

  // a channel raises at most one kind of error per cycle
  assign flag    = tmo_hit | mis_hit | stray_hit;
  assign any_err = |{tmo_err, mis_err, stray_err};

  always_comb begin
    n_flag = '0;
    lo_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) n_flag = n_flag + NW'(flag[i]);
    for (int i = NUM_CH - 1; i >= 0; i--) if (flag[i]) lo_ch = FE_W'(i);
  end

  // clr_err and new errors in the same cycle: clear first, then accumulate
  always_comb begin
    cnt_base = clr_err ? '0 : err_cnt;
    rec_base = clr_err ? 1'b0 : rec_q;
    sum      = SW'(cnt_base) + SW'(n_flag);
    cnt_nx   = (|sum[SW-1:ERRCNT_W]) ? '1 : sum[ERRCNT_W-1:0];
    rec_nx   = rec_base;
    first_nx = clr_err ? '0 : first_err_ch;
    if (!rec_base && (|flag)) begin
      rec_nx   = 1'b1;
      first_nx = lo_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_err      <= '0;
      mis_err      <= '0;
      stray_err    <= '0;
      err_cnt      <= '0;
      first_err_ch <= '0;
      rec_q        <= 1'b0;
    end else begin
      tmo_err      <= (clr_err ? '0 : tmo_err)   | tmo_hit;
      mis_err      <= (clr_err ? '0 : mis_err)   | mis_hit;
      stray_err    <= (clr_err ? '0 : stray_err) | stray_hit;
      err_cnt      <= cnt_nx;
      first_err_ch <= first_nx;
      rec_q        <= rec_nx;
    end
  end

endmodule

// File: tb/tb_resp_timeout_monitor.sv
module tb_resp_timeout_monitor;

  localparam int NCH = 4;
  localparam int CW  = 26;
  localparam int DW  = 8;
  localparam int EW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0]         arm = '0, chk_en = '0, evt = '0;
  logic [NCH-1:0][CW-1:0] limit = '0;
  logic [NCH-1:0][DW-1:0] exp_data = '0, evt_data = '0;
  logic                   clr_err = 1'b0;
  logic [NCH-1:0]         busy, done, pass, tmo_err, mis_err, stray_err;
  logic                   any_err;
  logic [1:0]             first_err_ch;
  logic [EW-1:0]          err_cnt;

  resp_timeout_monitor #(.NUM_CH(NCH), .CNT_W(CW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .limit(limit), .chk_en(chk_en),
    .exp_data(exp_data), .evt(evt), .evt_data(evt_data), .clr_err(clr_err),
    .busy(busy), .done(done), .pass(pass), .tmo_err(tmo_err), .mis_err(mis_err),
    .stray_err(stray_err), .any_err(any_err), .first_err_ch(first_err_ch),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected resolve pulses in order of arrival
  typedef struct {
    int ch;
    bit pass;
    int cyc;
  } sb_t;
  sb_t q[$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (pass[i] && !done[i]) chk("pass_without_done", 32'(i), 32'hFF);
        if (done[i]) begin
          if (q.size() == 0) begin
            chk("unexpected_done_ch", 32'(i), 32'hFF);
          end else begin
            sb_t s;
            s = q.pop_front();
            chk("done_ch", 32'(i), 32'(s.ch));
            chk("done_pass", 32'(pass[i]), 32'(s.pass));
            chk("done_cycle", 32'(cyc), 32'(s.cyc));
          end
        end
      end
    end
  end

  task automatic clear_and_check();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_any_err", 32'(any_err), 0);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_first", 32'(first_err_ch), 0);
  endtask

  typedef struct {
    int         ch;
    int         lim;
    bit         chk;
    logic [7:0] expd;
    logic [7:0] data;
    int         d;      // cycles from arm drive to evt drive; 0 = no event
    bit         epass;
    bit         etmo;
    bit         emis;
  } vec_t;
  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int c;
    c = cyc;
    limit[v.ch]    = CW'(v.lim);
    chk_en[v.ch]   = v.chk;
    exp_data[v.ch] = v.expd;
    arm[v.ch]      = 1'b1;
    q.push_back(sb_t'{v.ch, v.epass, (v.d != 0) ? c + v.d + 1 : c + 1 + v.lim});
    tick();
    arm = '0;
    chk("busy_armed", 32'(busy[v.ch]), 1);
    if (v.d != 0) begin
      while (cyc < c + v.d) tick();
      evt_data[v.ch] = v.data;
      evt[v.ch]      = 1'b1;
      tick();
      tick();
      evt[v.ch] = 1'b0;
    end else begin
      while (cyc < c + 2 + v.lim) tick();
    end
    chk("busy_after", 32'(busy[v.ch]), 0);
    chk("tmo_err", 32'(tmo_err[v.ch]), 32'(v.etmo));
    chk("mis_err", 32'(mis_err[v.ch]), 32'(v.emis));
    chk("any_err", 32'(any_err), 32'(v.etmo | v.emis));
    if (v.etmo | v.emis) begin
      chk("first_err_ch", 32'(first_err_ch), 32'(v.ch));
      chk("err_cnt", 32'(err_cnt), 1);
    end
    clear_and_check();
  endtask

  initial begin
    int c, c2;
    vt[0] = '{0, 100, 1'b1, 8'hA5, 8'hA5, 40, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1, 50,  1'b0, 8'h00, 8'h00, 0,  1'b0, 1'b1, 1'b0};
    vt[2] = '{2, 100, 1'b1, 8'h5A, 8'hA5, 10, 1'b0, 1'b0, 1'b1};
    vt[3] = '{3, 20,  1'b1, 8'h5A, 8'h5A, 20, 1'b1, 1'b0, 1'b0};
    vt[4] = '{0, 0,   1'b0, 8'h00, 8'h00, 300, 1'b1, 1'b0, 1'b0};
    vt[5] = '{2, 30,  1'b0, 8'hA5, 8'h00, 5,  1'b1, 1'b0, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sticky", 32'({tmo_err, mis_err, stray_err}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first", 32'(first_err_ch), 0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // stray rise on an idle channel
    evt[3] = 1'b1;
    tick();
    chk("stray_err", 32'(stray_err), 32'h8);
    chk("stray_first", 32'(first_err_ch), 3);
    chk("stray_cnt", 32'(err_cnt), 1);
    evt[3] = 1'b0;
    tick();

    // arm and rise together while idle: arm only, then time out
    c = cyc;
    limit[3] = 26'd10; chk_en[3] = 1'b0; arm[3] = 1'b1; evt[3] = 1'b1;
    q.push_back(sb_t'{3, 1'b0, c + 11});
    tick();
    arm = '0;
    evt[3] = 1'b0;
    chk("idle_arm_rise_nostray", 32'(stray_err[3]), 1);  // still set from above
    clear_and_check();
    while (cyc < c + 12) tick();
    chk("idle_arm_rise_stray", 32'(stray_err[3]), 0);
    chk("idle_arm_rise_tmo", 32'(tmo_err[3]), 1);
    clear_and_check();

    // re-arm at cycle 30 of a 40 budget: no done at 40, timeout 40 later
    c = cyc;
    limit[0] = 26'd40; arm[0] = 1'b1;
    tick();
    arm = '0;
    while (cyc < c + 30) tick();
    c2 = cyc;
    arm[0] = 1'b1;
    q.push_back(sb_t'{0, 1'b0, c2 + 41});
    tick();
    arm = '0;
    while (cyc < c2 + 42) tick();
    chk("rearm_tmo", 32'(tmo_err[0]), 1);
    clear_and_check();

    // arm and rise in the same WAIT cycle: old passes, new request times out
    c = cyc;
    limit[2] = 26'd100; chk_en[2] = 1'b1; exp_data[2] = 8'hA5; arm[2] = 1'b1;
    tick();
    arm = '0;
    repeat (5) tick();
    c2 = cyc;
    evt_data[2] = 8'hA5; evt[2] = 1'b1;
    arm[2] = 1'b1; limit[2] = 26'd10; chk_en[2] = 1'b0;
    q.push_back(sb_t'{2, 1'b1, c2 + 1});
    q.push_back(sb_t'{2, 1'b0, c2 + 11});
    tick();
    arm = '0;
    chk("wait_arm_rise_busy", 32'(busy[2]), 1);
    tick();
    evt[2] = 1'b0;
    while (cyc < c2 + 12) tick();
    chk("wait_arm_rise_tmo", 32'(tmo_err[2]), 1);
    chk("wait_arm_rise_mis", 32'(mis_err[2]), 0);
    clear_and_check();

    // clr_err in the same cycle as a new error: old cleared, new kept
    evt[3] = 1'b1;
    tick();
    evt[3] = 1'b0;
    c = cyc;
    limit[1] = 26'd5; arm[1] = 1'b1;
    q.push_back(sb_t'{1, 1'b0, c + 6});
    tick();
    arm = '0;
    while (cyc < c + 5) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_set_stray", 32'(stray_err), 0);
    chk("clr_set_tmo", 32'(tmo_err), 32'h2);
    chk("clr_set_cnt", 32'(err_cnt), 1);
    chk("clr_set_first", 32'(first_err_ch), 1);
    clear_and_check();

    // reset mid-wait: channel drops immediately, no done afterwards
    limit[1] = 26'd50; arm[1] = 1'b1;
    tick();
    arm = '0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    repeat (60) tick();
    chk("midrst_after_busy", 32'(busy), 0);

    // all channels time out together: err_cnt saturates, lowest index wins
    c = cyc;
    for (int i = 0; i < NCH; i++) begin
      limit[i] = 26'd10;
      chk_en[i] = 1'b0;
      q.push_back(sb_t'{i, 1'b0, c + 11});
    end
    arm = '1;
    tick();
    arm = '0;
    while (cyc < c + 12) tick();
    chk("all_tmo", 32'(tmo_err), 32'hF);
    chk("all_cnt_sat", 32'(err_cnt), 3);
    chk("all_first", 32'(first_err_ch), 0);
    chk("all_any", 32'(any_err), 1);
    clear_and_check();

    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
